// File: rtl/valve_pkg.sv
// rtl/valve_pkg.sv - shared command, state and error-code definitions for the valve driver
package valve_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'b00,
        DIR_A = 2'b01,
        DIR_B = 2'b10,
        AGUA  = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } chan_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;

endpackage

// File: rtl/valve_channel.sv
// rtl/valve_channel.sv - one zone actuator FSM with minimum on-time and dead time
module valve_channel
    import valve_pkg::*;
#(
    parameter int DEAD_CYC   = 16,
    parameter int MIN_ON_CYC = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cmd,
    input  logic       kill,
    output logic [1:0] drv,
    output logic       run
);

    localparam int ON_W   = (MIN_ON_CYC > 0) ? $clog2(MIN_ON_CYC + 1) : 1;
    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [ON_W-1:0]   ON_MAX    = ON_W'(MIN_ON_CYC);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);

    chan_state_t       state_q, state_d;
    logic [1:0]        cur_q, cur_d;
    logic [ON_W-1:0]   on_q, on_d;
    logic [DEAD_W-1:0] dead_q, dead_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= STOP;
            on_q    <= '0;
            dead_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            on_q    <= on_d;
            dead_q  <= dead_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        on_d    = on_q;
        dead_d  = dead_q;
        if (kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd != STOP) begin
                        state_d = RUN;
                        cur_d   = cmd;
                        on_d    = '0;
                    end
                end
                RUN: begin
                    if (on_q != ON_MAX) on_d = on_q + 1'b1;
                    // Requests arriving before the hold expires are dropped, not queued
                    if (cmd != cur_q && on_q == ON_MAX) begin
                        if (cmd == STOP) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DEAD;
                            dead_d  = '0;
                        end
                    end
                end
                DEAD: begin
                    dead_d = dead_q + 1'b1;
                    if (dead_q == DEAD_LAST) begin
                        if (cmd == STOP) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RUN;
                            cur_d   = cmd;
                            on_d    = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        drv = STOP;
        run = 1'b0;
        if (state_q == RUN) begin
            drv = cur_q;
            run = 1'b1;
        end
    end

endmodule

// File: rtl/valve_driver.sv
// rtl/valve_driver.sv - two-zone actuator output stage with fault alarm, blink LED and fault counter
module valve_driver
    import valve_pkg::*;
#(
    parameter int DEAD_CYC   = 16,
    parameter int MIN_ON_CYC = 64,
    parameter int BLINK_CYC  = 1000,
    parameter int FCNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        r1,
    input  logic [1:0]        r2,
    input  logic [1:0]        e,
    input  logic              ack,
    output logic [1:0]        drv1,
    output logic [1:0]        drv2,
    output logic              run1,
    output logic              run2,
    output logic              alarm,
    output logic              alarm_led,
    output logic [FCNT_W-1:0] fault_cnt
);

    localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

    logic               fault, kill;
    logic               alarm_q, alarm_d;
    logic               fault_prev_q;
    logic               led_q, led_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;

    assign fault = (e != ERR_NONE);
    assign kill  = alarm_q | fault;

    // A fault arriving together with ack wins, so the alarm can never be cleared mid-fault
    assign alarm_d = fault ? 1'b1 : (ack ? 1'b0 : alarm_q);
    assign fcnt_d  = (fault && !fault_prev_q && fcnt_q != '1) ? fcnt_q + 1'b1 : fcnt_q;

    always_comb begin
        led_d   = led_q;
        blink_d = blink_q;
        if (!alarm_d) begin
            led_d   = 1'b0;
            blink_d = '0;
        end else if (!alarm_q) begin
            led_d   = 1'b1;
            blink_d = '0;
        end else if (blink_q == BLINK_LAST) begin
            led_d   = !led_q;
            blink_d = '0;
        end else begin
            blink_d = blink_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_q      <= 1'b0;
            fault_prev_q <= 1'b0;
            led_q        <= 1'b0;
            blink_q      <= '0;
            fcnt_q       <= '0;
        end else begin
            alarm_q      <= alarm_d;
            fault_prev_q <= fault;
            led_q        <= led_d;
            blink_q      <= blink_d;
            fcnt_q       <= fcnt_d;
        end
    end

    valve_channel #(.DEAD_CYC(DEAD_CYC), .MIN_ON_CYC(MIN_ON_CYC)) u_chan1 (
        .clk   (clk),
        .reset (reset),
        .cmd   (r1),
        .kill  (kill),
        .drv   (drv1),
        .run   (run1)
    );

    valve_channel #(.DEAD_CYC(DEAD_CYC), .MIN_ON_CYC(MIN_ON_CYC)) u_chan2 (
        .clk   (clk),
        .reset (reset),
        .cmd   (r2),
        .kill  (kill),
        .drv   (drv2),
        .run   (run2)
    );

    assign alarm     = alarm_q;
    assign alarm_led = led_q;
    assign fault_cnt = fcnt_q;

endmodule
